// File: rtl/digital_clock_alarm.sv
// BCD hh:mm:ss clock with internal seconds prescaler, checked time loading,
// 12/24-hour display, timed alarm with acknowledge and top-of-hour chime.
module digital_clock_alarm #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int ALARM_SECS = 30,
  parameter int DIV_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] ld_hour,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_sec,
  input  logic       alm_set,
  input  logic       alm_en,
  input  logic       alm_ack,
  input  logic       mode_12h,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       sec_tick,
  output logic       tweet,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       RING_LOAD = 8'(ALARM_SECS);

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       hour_r, min_r, sec_r;
  logic [7:0]       alm_hour, alm_min;
  logic [7:0]       ring_cnt;
  logic [7:0]       nxt_hour, nxt_min, nxt_sec;
  logic             sec_tick_r, tweet_r, alarm_r, load_err_r;
  logic             tick, sec_wrap, min_wrap;
  logic             ld_time_ok, ld_alm_ok, load_ok, alarm_hit;
  logic [7:0]       hour_disp;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick       = en && (div_cnt == DIV_LAST);
  assign ld_time_ok = bcd_ok(ld_hour, 8'h23) && bcd_ok(ld_min, 8'h59) && bcd_ok(ld_sec, 8'h59);
  assign ld_alm_ok  = bcd_ok(ld_hour, 8'h23) && bcd_ok(ld_min, 8'h59);
  assign load_ok    = load && ld_time_ok;

  assign sec_wrap = (sec_r == 8'h59);
  assign min_wrap = (min_r == 8'h59);
  assign nxt_sec  = sec_wrap ? 8'h00 : bcd_inc(sec_r);
  assign nxt_min  = sec_wrap ? (min_wrap ? 8'h00 : bcd_inc(min_r)) : min_r;
  assign nxt_hour = (sec_wrap && min_wrap) ? ((hour_r == 8'h23) ? 8'h00 : bcd_inc(hour_r)) : hour_r;

  // A load in the same cycle as a tick swallows the tick, so it cannot trigger either
  assign alarm_hit = tick && !load_ok && alm_en && (nxt_sec == 8'h00) &&
                     (nxt_min == alm_min) && (nxt_hour == alm_hour);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      hour_r     <= 8'h00;
      min_r      <= 8'h00;
      sec_r      <= 8'h00;
      alm_hour   <= 8'h00;
      alm_min    <= 8'h00;
      sec_tick_r <= 1'b0;
      tweet_r    <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      sec_tick_r <= 1'b0;
      tweet_r    <= 1'b0;
      load_err_r <= (load && !ld_time_ok) || (alm_set && !ld_alm_ok);
      if (load_ok) begin
        hour_r  <= ld_hour;
        min_r   <= ld_min;
        sec_r   <= ld_sec;
        div_cnt <= '0;
      end else if (tick) begin
        hour_r     <= nxt_hour;
        min_r      <= nxt_min;
        sec_r      <= nxt_sec;
        div_cnt    <= '0;
        sec_tick_r <= 1'b1;
        tweet_r    <= sec_wrap && min_wrap;
      end else if (en) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (alm_set && ld_alm_ok) begin
        alm_hour <= ld_hour;
        alm_min  <= ld_min;
      end
    end
  end

  // Ringing drops one cycle after the last tick has run the counter down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_r  <= 1'b0;
      ring_cnt <= 8'd0;
    end else if (alm_ack || !alm_en) begin
      alarm_r  <= 1'b0;
      ring_cnt <= 8'd0;
    end else if (alarm_hit) begin
      alarm_r  <= 1'b1;
      ring_cnt <= RING_LOAD;
    end else if (alarm_r) begin
      if (ring_cnt == 8'd0)
        alarm_r <= 1'b0;
      else if (tick && !load_ok)
        ring_cnt <= ring_cnt - 8'd1;
    end
  end

  always_comb begin
    hour_disp = hour_r;
    if (mode_12h) begin
      case (hour_r)
        8'h00:   hour_disp = 8'h12;
        8'h13:   hour_disp = 8'h01;
        8'h14:   hour_disp = 8'h02;
        8'h15:   hour_disp = 8'h03;
        8'h16:   hour_disp = 8'h04;
        8'h17:   hour_disp = 8'h05;
        8'h18:   hour_disp = 8'h06;
        8'h19:   hour_disp = 8'h07;
        8'h20:   hour_disp = 8'h08;
        8'h21:   hour_disp = 8'h09;
        8'h22:   hour_disp = 8'h10;
        8'h23:   hour_disp = 8'h11;
        default: hour_disp = hour_r;
      endcase
    end
  end

  assign hour     = hour_disp;
  assign min      = min_r;
  assign sec      = sec_r;
  assign pm       = (hour_r >= 8'h12);
  assign sec_tick = sec_tick_r;
  assign tweet    = tweet_r;
  assign alarm    = alarm_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_digital_clock_alarm.sv
// Scoreboard bench for digital_clock_alarm: expected second ticks and load_err
// pulses are queued by the stimulus and checked by an independent monitor.
module tb_digital_clock_alarm;

  logic       clk = 1'b0;
  logic       rst, en, load, alm_set, alm_en, alm_ack, mode_12h;
  logic [7:0] ld_hour, ld_min, ld_sec;
  logic [7:0] hour, min, sec;
  logic       pm, sec_tick, tweet, alarm, load_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [7:0] hour, min, sec;
    logic       pm, tweet, alarm, chk_alarm;
  } exp_t;

  exp_t  sb_q[$];
  string err_q[$];
  exp_t  mon_e;
  string mon_s;

  digital_clock_alarm #(.TICK_DIV(4), .ALARM_SECS(3), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
    .alm_set(alm_set), .alm_en(alm_en), .alm_ack(alm_ack), .mode_12h(mode_12h),
    .hour(hour), .min(min), .sec(sec), .pm(pm),
    .sec_tick(sec_tick), .tweet(tweet), .alarm(alarm), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic do_load, input logic do_set,
                               input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    ld_hour = h;
    ld_min  = m;
    ld_sec  = s;
    load    = do_load;
    alm_set = do_set;
    step(1);
    load    = 1'b0;
    alm_set = 1'b0;
  endtask

  task automatic expect_tick(input string name, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s, input logic p, input logic tw,
                             input logic al, input logic chk_al);
    exp_t e;
    e.name = name; e.hour = h; e.min = m; e.sec = s;
    e.pm = p; e.tweet = tw; e.alarm = al; e.chk_alarm = chk_al;
    sb_q.push_back(e);
  endtask

  task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic p);
    checkOutput({name, "_hour"}, hour, h);
    checkOutput({name, "_min"}, min, m);
    checkOutput({name, "_sec"}, sec, s);
    checkOutput({name, "_pm"}, 8'(pm), 8'(p));
  endtask

  // Monitor: every sec_tick consumes one queued expectation, every load_err one error entry
  always @(negedge clk) begin
    if (sec_tick) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL unexpected_sec_tick: got time %h:%h:%h expected no tick", hour, min, sec);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput({mon_e.name, "_hour"}, hour, mon_e.hour);
        checkOutput({mon_e.name, "_min"}, min, mon_e.min);
        checkOutput({mon_e.name, "_sec"}, sec, mon_e.sec);
        checkOutput({mon_e.name, "_pm"}, 8'(pm), 8'(mon_e.pm));
        checkOutput({mon_e.name, "_tweet"}, 8'(tweet), 8'(mon_e.tweet));
        if (mon_e.chk_alarm)
          checkOutput({mon_e.name, "_alarm"}, 8'(alarm), 8'(mon_e.alarm));
      end
    end else if (tweet) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL stray_tweet: got tweet=1 without sec_tick expected 0");
    end
    if (load_err) begin
      if (err_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL unexpected_load_err: got 1 expected 0");
      end else begin
        mon_s = err_q.pop_front();
        checkOutput(mon_s, 8'(load_err), 8'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; alm_set = 1'b0; alm_en = 1'b0;
    alm_ack = 1'b0; mode_12h = 1'b0; ld_hour = 8'h00; ld_min = 8'h00; ld_sec = 8'h00;
    step(2);
    check_time("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("reset_alarm", 8'(alarm), 8'd0);
    checkOutput("reset_load_err", 8'(load_err), 8'd0);
    checkOutput("reset_sec_tick", 8'(sec_tick), 8'd0);
    rst = 1'b0;

    // 40 enabled cycles at TICK_DIV=4 give ten ticks, then a frozen stretch
    for (int i = 1; i <= 10; i++)
      expect_tick("run", 8'h00, 8'h00, {4'(i / 10), 4'(i % 10)}, 1'b0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    step(40);
    en = 1'b0;
    step(10);
    checkOutput("frozen_sec", sec, 8'h10);

    // Day rollover with chime
    applyStimulus(1'b1, 1'b0, 8'h23, 8'h59, 8'h58);
    check_time("load_235958", 8'h23, 8'h59, 8'h58, 1'b1);
    expect_tick("roll_59", 8'h23, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_tick("roll_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    en = 1'b1;
    step(8);
    en = 1'b0;

    // Rejected loads leave the time alone
    err_q.push_back("err_hour24");
    applyStimulus(1'b1, 1'b0, 8'h24, 8'h00, 8'h00);
    step(1);
    check_time("after_err_hour", 8'h00, 8'h00, 8'h00, 1'b0);
    err_q.push_back("err_min5A");
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h5A, 8'h00);
    step(1);
    check_time("after_err_min", 8'h00, 8'h00, 8'h00, 1'b0);

    // Load coinciding with a prescaler wrap discards the tick
    en = 1'b1;
    step(3);
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h00, 8'h00);
    check_time("load_on_wrap", 8'h12, 8'h00, 8'h00, 1'b1);
    expect_tick("post_wrap", 8'h12, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    checkOutput("wrap_restart_sec", sec, 8'h00);
    step(1);
    step(2);
    applyStimulus(1'b1, 1'b0, 8'h06, 8'h15, 8'h30);
    expect_tick("mid_load", 8'h06, 8'h15, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1);
    step(3);
    checkOutput("mid_restart_sec", sec, 8'h30);
    step(1);
    en = 1'b0;

    // Alarm rings for three seconds
    alm_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h07, 8'h30, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h29, 8'h59);
    expect_tick("ring0", 8'h07, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_tick("ring1", 8'h07, 8'h30, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_tick("ring2", 8'h07, 8'h30, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_tick("ring3", 8'h07, 8'h30, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_tick("ring4", 8'h07, 8'h30, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    step(20);
    en = 1'b0;

    // Acknowledge cuts ringing short
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h29, 8'h59);
    expect_tick("ack0", 8'h07, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_tick("ack1", 8'h07, 8'h30, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    en = 1'b1;
    step(8);
    alm_ack = 1'b1;
    step(1);
    alm_ack = 1'b0;
    checkOutput("ack_alarm", 8'(alarm), 8'd0);
    expect_tick("ack2", 8'h07, 8'h30, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    step(3);
    en = 1'b0;

    // Disarmed crossing and exact-time load stay silent
    alm_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h29, 8'h59);
    expect_tick("disarmed", 8'h07, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    step(4);
    en = 1'b0;
    alm_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h30, 8'h00);
    checkOutput("exact_load_alarm", 8'(alarm), 8'd0);
    expect_tick("exact_next", 8'h07, 8'h30, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    step(4);
    en = 1'b0;

    // 12-hour display mapping
    mode_12h = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    check_time("h12_00", 8'h12, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h11, 8'h00, 8'h00);
    check_time("h12_11", 8'h11, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h00, 8'h00);
    check_time("h12_12", 8'h12, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h13, 8'h00, 8'h00);
    check_time("h12_13", 8'h01, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h23, 8'h00, 8'h00);
    check_time("h12_23", 8'h11, 8'h00, 8'h00, 1'b1);

    // Reset while ringing
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h29, 8'h59);
    expect_tick("pre_rst_ring", 8'h07, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    en = 1'b1;
    step(5);
    en = 1'b0;
    rst = 1'b1;
    step(1);
    check_time("rst_ring", 8'h12, 8'h00, 8'h00, 1'b0);
    checkOutput("rst_ring_alarm", 8'(alarm), 8'd0);
    checkOutput("rst_ring_sec_tick", 8'(sec_tick), 8'd0);
    checkOutput("rst_ring_tweet", 8'(tweet), 8'd0);
    checkOutput("rst_ring_load_err", 8'(load_err), 8'd0);
    rst = 1'b0;
    mode_12h = 1'b0;
    #1;
    checkOutput("rst_hour_24h", hour, 8'h00);

    step(3);
    checkOutput("sb_tick_drain", 8'(sb_q.size()), 8'd0);
    checkOutput("sb_err_drain", 8'(err_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
